// File: rtl/nonrestoring_divider.sv
// Signed non-restoring divider: one quotient bit per cycle, results truncated
// toward zero with the remainder taking the dividend's sign.
module nonrestoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_lat, b_lat, d, q;
  logic [WIDTH:0]   p, d_ext, p_shift, p_step;
  logic [CW-1:0]    cnt;
  logic             neg_q, neg_r, dz;
  logic             a_sign, b_sign;
  logic [WIDTH-1:0] a_mag, b_mag, rem_mag, q_out, r_out;

  // Magnitudes are unsigned, so the most-negative operand maps to 2^(WIDTH-1).
  always_comb begin
    a_sign  = a_lat[WIDTH-1];
    b_sign  = b_lat[WIDTH-1];
    a_mag   = (a_lat ^ {WIDTH{a_sign}}) + WIDTH'(a_sign);
    b_mag   = (b_lat ^ {WIDTH{b_sign}}) + WIDTH'(b_sign);
    d_ext   = {1'b0, d};
    p_shift = {p[WIDTH-1:0], q[WIDTH-1]};
    p_step  = p[WIDTH] ? (p_shift + d_ext) : (p_shift - d_ext);
    rem_mag = p[WIDTH] ? (p[WIDTH-1:0] + d) : p[WIDTH-1:0];
    q_out   = neg_q ? -q : q;
    r_out   = neg_r ? -rem_mag : rem_mag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // A zero divisor still passes through FIX (with the correction bypassed)
  // so its result lands three cycles after start.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = PREP;
      PREP:    state_next = (b_lat == '0) ? FIX : ITER;
      ITER:    if (cnt == CW'(1)) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_lat       <= '0;
      b_lat       <= '0;
      d           <= '0;
      q           <= '0;
      p           <= '0;
      cnt         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      dz          <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_lat <= dividend;
          b_lat <= divisor;
          dz    <= 1'b0;
        end
        PREP: begin
          dz    <= (b_lat == '0);
          d     <= b_mag;
          q     <= a_mag;
          p     <= '0;
          cnt   <= CW'(WIDTH);
          neg_q <= a_sign ^ b_sign;
          neg_r <= a_sign;
        end
        ITER: begin
          p   <= p_step;
          q   <= {q[WIDTH-2:0], ~p_step[WIDTH]};
          cnt <= cnt - CW'(1);
        end
        FIX: begin
          quotient    <= dz ? '1 : q_out;
          remainder   <= dz ? a_lat : r_out;
          div_by_zero <= dz;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == PREP) || (state == ITER) || (state == FIX);
  assign done = (state == DONE);

endmodule
